vga_text_console: RTL and testbench
===================================

Name: vga_text_console

Overview:
- Character-stream front end for the VGA text-mode path. It sits directly upstream of vga_ctrl.
- Accepts ASCII characters over a valid/ready handshake, tracks the cursor and interprets control codes.
- Writes {attr,char} cells into the text VRAM that vga_ctrl scans out.
- Scrolls by rotating a top-row offset rather than copying memory, and clears the newly exposed line.

Parameters:
COLS, 80, characters per row (640 px / 8 px glyph)
ROWS, 30, text rows (480 px / 16 px glyph)
ADDR_W, 12, VRAM address width; must satisfy ROWS*COLS <= 2**ADDR_W
DEFAULT_ATTR, 8'h07, attribute byte used for clear/blank cells

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  character available
in_ready  out  1  block can accept a character this cycle
in_char  in  8  ASCII code
in_attr  in  8  attribute byte for printable characters
vram_we  out  1  VRAM write strobe, one cell per cycle
vram_addr  out  ADDR_W  physical cell address = phys_row*COLS + x
vram_wdata  out  16  {attr[15:8], char[7:0]}
top_row  out  5  physical VRAM row shown at screen line 0 (consumed by vga_ctrl)
cursor_x  out  7  logical cursor column, 0..COLS-1
cursor_y  out  5  logical cursor row, 0..ROWS-1

Behaviour:
- phys_row = (top_row + logical_y) mod ROWS, computed without a divider (compare-and-subtract).
- All outputs are registered. in_ready = (state == IDLE), registered.
- Reset values: in_ready 0, vram_we 0, vram_addr 0, vram_wdata 0, top_row 0, cursor_x 0, cursor_y 0, state CLR_ALL, clear counter 0.
- States: CLR_ALL, IDLE, CLR_LINE.
- CLR_ALL:
  - Writes {DEFAULT_ATTR,8'h20} to addresses 0..ROWS*COLS-1, one per clock. Address k has vram_we=1 in cycle k+1 after the first edge following reset release.
  - Then goes to IDLE. top_row, cursor = 0.
- Handshake: a character is accepted on an edge where in_valid && in_ready. With no scroll, IDLE accepts one character per cycle.
- Effects of accepted character, registered at the accept edge (write visible in the next cycle):
  - Printable 0x20..0x7E:
    - Write {in_attr,in_char} at the pre-accept cursor.
    - If x < COLS-1, x+1; else x=0 and newline.
  - 0x0A LF: x=0, newline, no write.
  - 0x0D CR: x=0, no write.
  - 0x08 BS:
    - If x>0: x-1 and write {DEFAULT_ATTR,8'h20} at the new x.
    - If x==0: no change and no write (no reverse line wrap).
  - 0x0C FF: top_row=0, cursor=(0,0), enter CLR_ALL.
  - Any other code: consumed, no effect, vram_we=0.
- newline:
  - If y < ROWS-1: y+1.
  - Else: y stays ROWS-1, top_row = (top_row+1) mod ROWS (wraps ROWS-1 -> 0), enter CLR_LINE.
- CLR_LINE:
  - Writes {DEFAULT_ATTR,8'h20} to COLS cells of the new bottom physical row, which is the old top_row, x = 0..COLS-1.
  - in_ready=0 for exactly COLS cycles, then IDLE.
  - When the trigger was a printable char at the last row and last column, that char's write occurs in the accept+1 cycle. CLR_LINE writes begin in the following cycle, so they never collide with it.
- vram_we is 0 in every cycle with no write. vram_addr and vram_wdata hold their last values when vram_we=0.
- in_valid held with in_ready=0: nothing is consumed. in_char may change freely; it is not sampled until ready.
- Reset asserted mid-operation: all registers return to their reset values immediately. The full CLR_ALL reruns after release.
- Cursor outputs update in the same cycle as the corresponding write.

Test Plan:
- Release reset -> exactly 2400 writes with data 16'h0720 to addresses 0..2399 in consecutive cycles. in_ready rises the cycle after the last write. top_row=0, cursor=(0,0).
- Stream "AB" with attr 8'h1E, in_valid held -> writes 16'h1E41 @0 then 16'h1E42 @1 on consecutive cycles. cursor_x=2.
- At x=5, send 0x08 -> write 16'h0720 @4, cursor_x=4. At x=0, send 0x08 -> no write, cursor unchanged. Send 0x0D -> x=0, no write.
- Cursor (79,29) with top_row=0, send 'Z' -> write @2399. top_row becomes 1. Writes 16'h0720 @0..79 over 80 cycles with in_ready=0. cursor=(0,29), then in_ready=1.
- Scroll 30 times with LF from y=29 -> top_row wraps 29->0. Each scroll clears the correct physical row.
- Assert reset during a CLR_LINE (cycle 40 of 80) -> outputs return to reset values at once. A full 2400-cell clear follows release.

Source files
------------

// File: rtl/vga_text_console.sv
// ---------------------------------------------------------------------------
// vga_text_console: character stream to text-VRAM writer with cursor and
// rotating-offset scroll.                                   Revision 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module vga_text_console #(
  parameter int unsigned COLS         = 80,
  parameter int unsigned ROWS         = 30,
  parameter int unsigned ADDR_W       = 12,
  parameter logic [7:0]  DEFAULT_ATTR = 8'h07
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [7:0]        in_char_i,
  input  logic [7:0]        in_attr_i,
  output logic              vram_we_o,
  output logic [ADDR_W-1:0] vram_addr_o,
  output logic [15:0]       vram_wdata_o,
  output logic [4:0]        top_row_o,
  output logic [6:0]        cursor_x_o,
  output logic [4:0]        cursor_y_o
);

  typedef enum logic [1:0] {
    CLR_ALL  = 2'd0,
    IDLE     = 2'd1,
    CLR_LINE = 2'd2
  } state_e;

  localparam logic [ADDR_W-1:0] C_COLS      = ADDR_W'(COLS);
  localparam logic [ADDR_W-1:0] C_LAST_CELL = ADDR_W'(COLS * ROWS - 1);
  localparam logic [ADDR_W-1:0] C_LAST_COL  = ADDR_W'(COLS - 1);
  localparam logic [6:0]        C_X_LAST    = 7'(COLS - 1);
  localparam logic [4:0]        C_Y_LAST    = 5'(ROWS - 1);
  localparam logic [5:0]        C_ROWS      = 6'(ROWS);
  localparam logic [15:0]       C_BLANK     = {DEFAULT_ATTR, 8'h20};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [15:0]       wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              ready_q, ready_d;
  logic [4:0]        top_q, top_d;
  logic [4:0]        y_q, y_d;
  logic [6:0]        x_q, x_d;

  logic [5:0]        row_sum;
  logic [5:0]        phys_row;
  logic [ADDR_W-1:0] cur_addr;
  logic              accept;
  logic              printable;
  logic              newline;

  // top_row + y is below 2*ROWS, so one conditional subtract gives the modulo
  assign row_sum   = {1'b0, top_q} + {1'b0, y_q};
  assign phys_row  = (row_sum >= C_ROWS) ? (row_sum - C_ROWS) : row_sum;
  assign cur_addr  = ADDR_W'(phys_row) * C_COLS + ADDR_W'(x_q);
  assign accept    = in_valid_i && ready_q;
  assign printable = (in_char_i >= 8'h20) && (in_char_i <= 8'h7E);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    base_d  = base_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_d    = 1'b0;
    top_d   = top_q;
    x_d     = x_q;
    y_d     = y_q;
    newline = 1'b0;

    case (state_q)
      CLR_ALL: begin
        we_d    = 1'b1;
        addr_d  = cnt_q;
        wdata_d = C_BLANK;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == C_LAST_CELL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      CLR_LINE: begin
        we_d    = 1'b1;
        addr_d  = base_q + cnt_q;
        wdata_d = C_BLANK;
        cnt_d   = cnt_q + ADDR_W'(1);
        if (cnt_q == C_LAST_COL) begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      end

      IDLE: begin
        if (accept) begin
          if (printable) begin
            we_d    = 1'b1;
            addr_d  = cur_addr;
            wdata_d = {in_attr_i, in_char_i};
            if (x_q < C_X_LAST) begin
              x_d = x_q + 7'd1;
            end else begin
              x_d     = '0;
              newline = 1'b1;
            end
          end else begin
            case (in_char_i)
              8'h0A: begin
                x_d     = '0;
                newline = 1'b1;
              end
              8'h0D: x_d = '0;
              8'h08: begin
                if (x_q != '0) begin
                  x_d     = x_q - 7'd1;
                  we_d    = 1'b1;
                  addr_d  = cur_addr - ADDR_W'(1);
                  wdata_d = C_BLANK;
                end
              end
              8'h0C: begin
                state_d = CLR_ALL;
                cnt_d   = '0;
                top_d   = '0;
                x_d     = '0;
                y_d     = '0;
              end
              default: ;
            endcase
          end

          // Scrolling exposes the old top physical row as the new bottom line
          if (newline) begin
            if (y_q < C_Y_LAST) begin
              y_d = y_q + 5'd1;
            end else begin
              top_d   = (top_q == C_Y_LAST) ? 5'd0 : (top_q + 5'd1);
              base_d  = ADDR_W'(top_q) * C_COLS;
              cnt_d   = '0;
              state_d = CLR_LINE;
            end
          end
        end
      end

      default: state_d = CLR_ALL;
    endcase

    ready_d = (state_q == IDLE) && (state_d == IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= CLR_ALL;
      cnt_q   <= '0;
      base_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      ready_q <= 1'b0;
      top_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      base_q  <= base_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      ready_q <= ready_d;
      top_q   <= top_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  assign in_ready_o   = ready_q;
  assign vram_we_o    = we_q;
  assign vram_addr_o  = addr_q;
  assign vram_wdata_o = wdata_q;
  assign top_row_o    = top_q;
  assign cursor_x_o   = x_q;
  assign cursor_y_o   = y_q;

endmodule

`default_nettype wire

// File: tb/tb_vga_text_console.sv
// ---------------------------------------------------------------------------
// tb_vga_text_console: vector table, cycle-exact clear/scroll sequences and a
// random character stream checked against a logical-screen model.
// ---------------------------------------------------------------------------
`default_nettype none

module tb_vga_text_console;

  localparam int          COLS   = 80;
  localparam int          ROWS   = 30;
  localparam int          ADDR_W = 12;
  localparam int          CELLS  = COLS * ROWS;
  localparam logic [15:0] BLANK  = 16'h0720;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              in_valid = 1'b0;
  logic [7:0]        in_char = 8'h00;
  logic [7:0]        in_attr = 8'h00;
  logic              in_ready;
  logic              vram_we;
  logic [ADDR_W-1:0] vram_addr;
  logic [15:0]       vram_wdata;
  logic [4:0]        top_row;
  logic [6:0]        cursor_x;
  logic [4:0]        cursor_y;

  int total = 0;
  int bad   = 0;

  logic [15:0] dut_mem [CELLS];
  logic [15:0] scr [ROWS][COLS];
  int          m_x, m_y, m_top;

  typedef struct {
    logic [7:0]  ch;
    logic [7:0]  at;
    logic        we;
    int          addr;
    logic [15:0] data;
    int          x;
    int          y;
  } vec_t;
  vec_t tbl [14];

  vga_text_console #(
    .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DEFAULT_ATTR(8'h07)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_char_i(in_char), .in_attr_i(in_attr),
    .vram_we_o(vram_we), .vram_addr_o(vram_addr), .vram_wdata_o(vram_wdata),
    .top_row_o(top_row), .cursor_x_o(cursor_x), .cursor_y_o(cursor_y)
  );

  always #5 clk = ~clk;

  // Capture every VRAM write into a shadow memory, away from the active edge
  always @(negedge clk) begin
    if (rst_n === 1'b1 && vram_we === 1'b1) begin
      if (int'(vram_addr) < CELLS) dut_mem[int'(vram_addr)] = vram_wdata;
      else begin
        total++; bad++;
        $display("FAIL vram_addr_range: got %0d limit %0d", vram_addr, CELLS - 1);
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: no finish within 900000 ns, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Logical screen model: row 0 is the top line on the display
  task automatic model_reset();
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) scr[y][x] = BLANK;
    m_x = 0; m_y = 0; m_top = 0;
  endtask

  task automatic model_nl();
    if (m_y < ROWS - 1) m_y++;
    else begin
      for (int y = 0; y < ROWS - 1; y++)
        for (int x = 0; x < COLS; x++) scr[y][x] = scr[y + 1][x];
      for (int x = 0; x < COLS; x++) scr[ROWS - 1][x] = BLANK;
      m_top = (m_top + 1) % ROWS;
    end
  endtask

  task automatic model_apply(input logic [7:0] c, input logic [7:0] a);
    if (c >= 8'h20 && c <= 8'h7E) begin
      scr[m_y][m_x] = {a, c};
      if (m_x < COLS - 1) m_x++;
      else begin m_x = 0; model_nl(); end
    end else if (c == 8'h0A) begin
      m_x = 0; model_nl();
    end else if (c == 8'h0D) begin
      m_x = 0;
    end else if (c == 8'h08) begin
      if (m_x > 0) begin m_x--; scr[m_y][m_x] = BLANK; end
    end else if (c == 8'h0C) begin
      model_reset();
    end
  endtask

  // Offer one character; returns #1 after the accepting edge
  task automatic send(input logic [7:0] c, input logic [7:0] a);
    int guard = 0;
    @(negedge clk);
    in_valid = 1'b1;
    while (in_ready !== 1'b1) begin
      if (guard++ > 5000) begin
        total++; bad++; in_valid = 1'b0;
        $display("FAIL send_timeout: in_ready=%b expected 1 within 5000 cycles", in_ready);
        return;
      end
      in_char = 8'($urandom);
      in_attr = 8'($urandom);
      @(negedge clk);
    end
    in_char = c;
    in_attr = a;
    @(posedge clk); #1;
    in_valid = 1'b0;
    model_apply(c, a);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (in_ready !== 1'b1 && n < 5000) begin @(posedge clk); #1; n++; end
    if (in_ready !== 1'b1) begin
      total++; bad++;
      $display("FAIL wait_ready: in_ready=%b expected 1 within 5000 cycles", in_ready);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ready"}, in_ready, 0);
    chk({tag, "_we"}, vram_we, 0);
    chk({tag, "_addr"}, vram_addr, 0);
    chk({tag, "_wdata"}, vram_wdata, 0);
    chk({tag, "_top"}, top_row, 0);
    chk({tag, "_x"}, cursor_x, 0);
    chk({tag, "_y"}, cursor_y, 0);
  endtask

  task automatic check_clr_all(input string tag);
    int errs = 0;
    for (int k = 0; k < CELLS; k++) begin
      @(posedge clk); #1;
      if (!(vram_we === 1'b1 && int'(vram_addr) == k && vram_wdata === BLANK && in_ready === 1'b0)) begin
        if (errs == 0)
          $display("FAIL %s_clr_all cycle %0d: we=%b addr=%0d data=%h ready=%b, expected we=1 addr=%0d data=%h ready=0",
                   tag, k, vram_we, vram_addr, vram_wdata, in_ready, k, BLANK);
        errs++;
      end
    end
    total++;
    if (errs != 0) bad++;
    @(posedge clk); #1;
    chk({tag, "_clr_done_ready"}, in_ready, 1);
    chk({tag, "_clr_done_we"}, vram_we, 0);
    chk({tag, "_clr_done_top"}, top_row, 0);
    chk({tag, "_clr_done_x"}, cursor_x, 0);
    chk({tag, "_clr_done_y"}, cursor_y, 0);
  endtask

  task automatic check_screen(input string name);
    int errs = 0;
    int p;
    wait_ready();
    @(negedge clk); #1;
    for (int y = 0; y < ROWS; y++)
      for (int x = 0; x < COLS; x++) begin
        p = ((m_top + y) % ROWS) * COLS + x;
        if (dut_mem[p] !== scr[y][x]) begin
          if (errs == 0)
            $display("FAIL %s_screen line %0d col %0d: got %h expected %h", name, y, x, dut_mem[p], scr[y][x]);
          errs++;
        end
      end
    total++;
    if (errs != 0) bad++;
    chk({name, "_top"}, top_row, m_top);
    chk({name, "_x"}, cursor_x, m_x);
    chk({name, "_y"}, cursor_y, m_y);
  endtask

  initial begin
    int          errs;
    int          r;
    logic [7:0]  c;

    for (int k = 0; k < CELLS; k++) dut_mem[k] = 16'hDEAD;
    model_reset();

    tbl[0]  = '{8'h41, 8'h1E, 1'b1, 0,  16'h1E41, 1, 0};
    tbl[1]  = '{8'h42, 8'h1E, 1'b1, 1,  16'h1E42, 2, 0};
    tbl[2]  = '{8'h0D, 8'h55, 1'b0, 0,  16'h0000, 0, 0};
    tbl[3]  = '{8'h08, 8'h55, 1'b0, 0,  16'h0000, 0, 0};
    tbl[4]  = '{8'h43, 8'h2F, 1'b1, 0,  16'h2F43, 1, 0};
    tbl[5]  = '{8'h0A, 8'h11, 1'b0, 0,  16'h0000, 0, 1};
    tbl[6]  = '{8'h44, 8'h07, 1'b1, 80, 16'h0744, 1, 1};
    tbl[7]  = '{8'h45, 8'h07, 1'b1, 81, 16'h0745, 2, 1};
    tbl[8]  = '{8'h08, 8'hAA, 1'b1, 81, 16'h0720, 1, 1};
    tbl[9]  = '{8'h7E, 8'h05, 1'b1, 81, 16'h057E, 2, 1};
    tbl[10] = '{8'h7F, 8'h05, 1'b0, 0,  16'h0000, 2, 1};
    tbl[11] = '{8'h1F, 8'h05, 1'b0, 0,  16'h0000, 2, 1};
    tbl[12] = '{8'h20, 8'h33, 1'b1, 82, 16'h3320, 3, 1};
    tbl[13] = '{8'h00, 8'h33, 1'b0, 0,  16'h0000, 3, 1};

    repeat (3) @(posedge clk);
    #1;
    check_reset_vals("por");
    @(negedge clk);
    rst_n = 1'b1;
    check_clr_all("por");

    // Back-to-back single characters from the home position
    for (int i = 0; i < 14; i++) begin
      send(tbl[i].ch, tbl[i].at);
      chk($sformatf("vec%0d_we", i), vram_we, tbl[i].we);
      if (tbl[i].we) begin
        chk($sformatf("vec%0d_addr", i), vram_addr, tbl[i].addr);
        chk($sformatf("vec%0d_data", i), vram_wdata, tbl[i].data);
      end
      chk($sformatf("vec%0d_x", i), cursor_x, tbl[i].x);
      chk($sformatf("vec%0d_y", i), cursor_y, tbl[i].y);
      chk($sformatf("vec%0d_ready", i), in_ready, 1);
    end
    check_screen("table");

    send(8'h0C, 8'h00);
    chk("ff_we", vram_we, 0);
    chk("ff_ready", in_ready, 0);
    chk("ff_x", cursor_x, 0);
    chk("ff_y", cursor_y, 0);
    check_clr_all("ff");

    // Fill to the last cell, then a printable char triggers the first scroll
    for (int i = 0; i < ROWS - 1; i++) send(8'h0A, 8'h00);
    for (int i = 0; i < COLS - 1; i++) send(8'($urandom_range(32, 126)), 8'($urandom));
    chk("pre_z_x", cursor_x, COLS - 1);
    chk("pre_z_y", cursor_y, ROWS - 1);
    send(8'h5A, 8'h4A);
    chk("z_we", vram_we, 1);
    chk("z_addr", vram_addr, CELLS - 1);
    chk("z_data", vram_wdata, 16'h4A5A);
    chk("z_top", top_row, 1);
    chk("z_x", cursor_x, 0);
    chk("z_y", cursor_y, ROWS - 1);
    chk("z_ready", in_ready, 0);
    errs = 0;
    in_valid = 1'b1;
    for (int i = 0; i < COLS; i++) begin
      in_char = 8'($urandom_range(32, 126));
      @(posedge clk); #1;
      if (!(vram_we === 1'b1 && int'(vram_addr) == i && vram_wdata === BLANK && in_ready === 1'b0 &&
            cursor_x === 7'd0 && int'(cursor_y) == ROWS - 1)) begin
        if (errs == 0)
          $display("FAIL clr_line cycle %0d: we=%b addr=%0d data=%h ready=%b x=%0d y=%0d, expected we=1 addr=%0d data=%h ready=0 x=0 y=%0d",
                   i, vram_we, vram_addr, vram_wdata, in_ready, cursor_x, cursor_y, i, BLANK, ROWS - 1);
        errs++;
      end
    end
    in_valid = 1'b0;
    total++;
    if (errs != 0) bad++;
    @(posedge clk); #1;
    chk("clr_line_done_ready", in_ready, 1);
    chk("clr_line_done_we", vram_we, 0);
    check_screen("after_z");

    // A full revolution of the top-row offset
    for (int i = 0; i < ROWS; i++) begin
      send(8'h0A, 8'h00);
      chk($sformatf("lf%0d_top", i), top_row, m_top);
    end
    chk("lf_wrap_top", top_row, 1);
    check_screen("after_lf");

    for (int i = 0; i < 300; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 70)      c = 8'($urandom_range(32, 126));
      else if (r < 80) c = 8'h0A;
      else if (r < 85) c = 8'h0D;
      else if (r < 93) c = 8'h08;
      else if (r < 94) c = 8'h0C;
      else begin
        c = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 31)) : 8'($urandom_range(127, 255));
        if (c == 8'h08 || c == 8'h0A || c == 8'h0C || c == 8'h0D) c = 8'h1B;
      end
      send(c, 8'($urandom));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      if (i % 60 == 59) check_screen($sformatf("rand%0d", i));
    end

    // Reset in the middle of a line clear
    while (m_y < ROWS - 1) send(8'h0A, 8'h00);
    send(8'h0A, 8'h00);
    repeat (40) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("midclr");
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check_clr_all("rst");
    check_screen("final");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
